// File: rtl/vga_mem_viewer.sv
// Hex-dump overlay of the 32-byte data memory: 4 rows x 8 bytes, 2x-scaled 8x8 glyphs.
// Snapshots memory on each vsync falling edge and delays pixel/sync by exactly two clocks.
module vga_mem_viewer #(
   parameter int unsigned X0 = 64,
   parameter int unsigned Y0 = 64,
   parameter logic [23:0] FG = 24'hFFFFFF,
   parameter logic [23:0] BG = 24'h000080
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] mem_bytes [0:31],
   input  logic       freeze,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       video_on,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       video_on_out,
   output logic       frame_snap
);

   localparam logic [9:0]  X0_W = 10'(X0);
   localparam logic [9:0]  Y0_W = 10'(Y0);
   localparam logic [10:0] X_LO = 11'(X0);
   localparam logic [10:0] X_HI = 11'(X0 + 512);
   localparam logic [10:0] Y_LO = 11'(Y0);
   localparam logic [10:0] Y_HI = 11'(Y0 + 128);

   // Hex digit glyphs, row 0 in bits 63:56, bit 7 of each row is the leftmost column.
   localparam logic [63:0] FONT_ROM [0:15] = '{
      64'h3C666E7666663C00, 64'h183818181818_7E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
      64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00, 64'h7E060C1830303000,
      64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
      64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607C60607E00, 64'h7E60607C60606000
   };

   function automatic logic font_bit(input logic [3:0] nib, input logic [2:0] row,
                                     input logic [2:0] col);
      logic [63:0] glyph;
      glyph = FONT_ROM[nib];
      return glyph[~{row, col}];
   endfunction

   logic [7:0] shadow_r [0:31];
   logic       vs_d_r;
   logic       snap_s;

   logic       in_region_s;
   logic       blank_s;
   logic [2:0] gcol_s;
   logic [1:0] cell_s;
   logic [2:0] bcol_s;
   logic [2:0] grow_s;
   logic       gap_s;
   logic [1:0] brow_s;
   logic [7:0] byte_s;
   logic [3:0] nib_s;

   logic       in_region_r;
   logic       blank_r;
   logic [3:0] nib_r;
   logic [2:0] grow_r;
   logic [2:0] gcol_r;
   logic       von_r;
   logic       hs_r;
   logic       vs_r;

   logic [23:0] colour_s;

   assign snap_s = vs_d_r & ~vsync_in & ~freeze;

   // Vsync edge-detect register and snapshot pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d_r     <= 1'b1;
         frame_snap <= 1'b0;
      end else begin
         vs_d_r     <= vsync_in;
         frame_snap <= snap_s;
      end
   end

   // Shadow copy of memory, refreshed only at an unfrozen vsync falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) shadow_r[i] <= 8'h00;
      end else if (snap_s) begin
         for (int i = 0; i < 32; i++) shadow_r[i] <= mem_bytes[i];
      end
   end

   // Region decode and nibble selection; wrapped offsets below X0/Y0 are masked by the region test.
   always_comb begin
      in_region_s = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                    ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
      gcol_s  = 3'((pixel_x - X0_W) >> 1);
      cell_s  = 2'((pixel_x - X0_W) >> 4);
      bcol_s  = 3'((pixel_x - X0_W) >> 6);
      grow_s  = 3'((pixel_y - Y0_W) >> 1);
      gap_s   = 1'((pixel_y - Y0_W) >> 4);
      brow_s  = 2'((pixel_y - Y0_W) >> 5);
      blank_s = gap_s | cell_s[1];
      byte_s  = shadow_r[{brow_s, bcol_s}];
      if (cell_s[0]) begin
         nib_s = byte_s[3:0];
      end else begin
         nib_s = byte_s[7:4];
      end
   end

   // Stage 1: geometry, nibble and delayed timing signals.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_region_r <= 1'b0;
         blank_r     <= 1'b0;
         nib_r       <= 4'h0;
         grow_r      <= 3'd0;
         gcol_r      <= 3'd0;
         von_r       <= 1'b0;
         hs_r        <= 1'b1;
         vs_r        <= 1'b1;
      end else begin
         in_region_r <= in_region_s;
         blank_r     <= blank_s;
         nib_r       <= nib_s;
         grow_r      <= grow_s;
         gcol_r      <= gcol_s;
         von_r       <= video_on;
         hs_r        <= hsync_in;
         vs_r        <= vsync_in;
      end
   end

   // Colour priority: blanking, outside region, gap/blank cell, glyph pixel, background.
   always_comb begin
      colour_s = 24'h000000;
      if (!von_r) begin
         colour_s = 24'h000000;
      end else if (!in_region_r) begin
         colour_s = 24'h000000;
      end else if (blank_r) begin
         colour_s = BG;
      end else if (font_bit(nib_r, grow_r, gcol_r)) begin
         colour_s = FG;
      end else begin
         colour_s = BG;
      end
   end

   // Stage 2: registered outputs to the DAC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_r        <= 8'h00;
         vga_g        <= 8'h00;
         vga_b        <= 8'h00;
         hsync_out    <= 1'b1;
         vsync_out    <= 1'b1;
         video_on_out <= 1'b0;
      end else begin
         vga_r        <= colour_s[23:16];
         vga_g        <= colour_s[15:8];
         vga_b        <= colour_s[7:0];
         hsync_out    <= hs_r;
         vsync_out    <= vs_r;
         video_on_out <= von_r;
      end
   end

endmodule

// File: doc/vga_mem_viewer.md
Name: vga_mem_viewer

Overview:
- Read-side display block for the processor's 32-byte data memory.
- Takes the data memory's exposed byte array and renders it as a hex dump: 4 rows of 8 bytes, two hex digits per byte.
- Sits between the VGA timing generator and the VGA DAC pins, and adds a fixed 2-clock pipeline delay to pixel and sync signals.
- Snapshots memory once per frame so a frame never shows a mix of old and new contents (no tearing).

Parameters:
- X0, 64: left pixel column of the dump region.
- Y0, 64: top pixel row of the dump region.
- FG, 24'hFFFFFF: RGB colour of glyph pixels.
- BG, 24'h000080: RGB colour of non-glyph pixels inside the region.

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  asynchronous reset, active-low.
- mem_bytes  input  8 x [0:31]  live data-memory bytes; index 0 is byte address 0.
- freeze  input  1  when 1, the snapshot is not updated.
- pixel_x  input  10  current pixel column.
- pixel_y  input  10  current pixel row.
- video_on  input  1  active-area flag.
- hsync_in  input  1  horizontal sync, active-low.
- vsync_in  input  1  vertical sync, active-low.
- vga_r, vga_g, vga_b  output  8 each  pixel colour.
- hsync_out, vsync_out  output  1 each  sync delayed 2 clocks.
- video_on_out  output  1  video_on delayed 2 clocks.
- frame_snap  output  1  one-clock pulse when a snapshot is taken.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - shadow[0:31] = 0.
  - vga_r/g/b = 0; hsync_out = 1; vsync_out = 1; video_on_out = 0; frame_snap = 0.
  - All pipeline registers are cleared to those same idle values.
  - Reset mid-frame blanks the output immediately.
- Snapshot:
  - vsync_in is registered once to vs_d.
  - On the cycle where vs_d=1 and vsync_in=0 (falling edge) and freeze=0: shadow <= mem_bytes, and frame_snap=1 on the next cycle.
  - If freeze=1 at the falling edge: no copy, no pulse.
  - Writes to memory during the frame are not visible until the next snapshot.
- Geometry (dx = pixel_x - X0, dy = pixel_y - Y0):
  - in_region when X0 <= pixel_x < X0+512 and Y0 <= pixel_y < Y0+128.
  - row = dy[6:5]; line = dy[4:0]. Lines 16..31 are a gap and render BG.
  - byte column = dx[8:6]; byte index = row*8 + column.
  - cell = dx[5:4]: cell 0 shows the high nibble, cell 1 the low nibble, cells 2-3 are blank (BG).
  - Glyphs are 8x8 drawn at 2x scale: glyph row = dy[3:1], glyph col = dx[3:1].
- Font ROM:
  - 16 entries (hex digits 0-F) x 8 rows x 8 bits; bit 7 of each row is the leftmost glyph column.
  - The ROM is a localparam table; the bench imports the identical table.
- Pipeline (exactly 2 cycles):
  - Stage 1 registers: in_region, gap/blank flag, selected nibble, glyph row, glyph col, video_on, hsync_in, vsync_in.
  - Stage 2 registers: the font bit and the final colour.
  - Inputs sampled at edge N appear on the outputs after edge N+2.
- Colour priority, highest first:
  1. video_on=0 → 0.
  2. Outside the region → 0.
  3. Gap line or blank cell → BG.
  4. Font bit = 1 → FG.
  5. Otherwise → BG.
- Other rules:
  - Only unsigned comparisons are used.
  - Arithmetic wrap of dx/dy below X0/Y0 is excluded by the region test.
  - pixel_x/pixel_y beyond 639/479 are treated like any other value.

Test Plan:
- Reset: assert rst_n=0 mid-line → same cycle: rgb=0, hsync_out=1, vsync_out=1, video_on_out=0; after release, shadow reads all zero and the first byte shows glyph "0" pixels.
- Latency: toggle hsync_in low at cycle 10 → hsync_out goes low at cycle 12; pixel (0,0) with video_on=1 → rgb=0 at cycle +2.
- Render: mem_bytes[0]=8'hA5, snapshot taken.
  - Pixel (64+2*c, 64+2*r) → FG iff font['A'][r][7-c], else BG.
  - Pixel (80+2*c, 64+2*r) uses glyph '5'.
  - Pixel (100, 64) → BG (blank cell).
- Indexing: mem_bytes[31]=8'h3C → glyph '3' at x=64+7*64=512, y=64+3*32=160; pixel (512, 176) → BG (gap line).
- Snapshot: change mem_bytes[4] mid-frame → display unchanged until the vsync_in falling edge, then frame_snap pulses once; with freeze=1 across a vsync edge → no pulse, old value retained.
- Boundaries: pixel_x=63 or 576, and pixel_y=63 or 192, with video_on=1 → rgb=0; video_on=0 inside the region → rgb=0.
